// File: rtl/fc_ctrl.sv
// fc_ctrl: sequences one fully connected layer through a single pe_fc.
// Every neuron takes IN_LEN read slots and then one bias slot. The PE control strobes
// are delayed copies of the issue strobes, lined up with the memory and PE latencies.
module fc_ctrl #(
    parameter int unsigned IN_LEN  = 192,
    parameter int unsigned OUT_LEN = 10,
    parameter int unsigned IN_AW   = 8,
    parameter int unsigned W_AW    = 11,
    parameter int unsigned OUT_AW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IN_AW-1:0]  data_addr,
    output logic [W_AW-1:0]   weight_addr,
    output logic              bias_rd_en,
    output logic [OUT_AW-1:0] bias_addr,
    output logic              pe_en,
    output logic              pe_flush,
    output logic              pe_bias_en,
    output logic              out_valid,
    output logic [OUT_AW-1:0] out_idx
);

    // The slot counter must reach IN_LEN, which marks the bias slot.
    localparam int unsigned KW = $clog2(IN_LEN + 1);
    localparam logic [KW-1:0]     KLast = KW'(IN_LEN);
    localparam logic [OUT_AW-1:0] NLast = OUT_AW'(OUT_LEN - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [OUT_AW-1:0] n_q, n_d;
    logic [W_AW-1:0]   w_q, w_d;
    logic              read_slot, bias_slot, rd_next;

    // Delay stages between the issue strobes and the PE controls
    logic              flush_p1_q, en_p1_q;
    logic [OUT_AW-1:0] bias_idx_p2_q;

    // Next-state logic: walk k over read slots plus the bias slot, then advance n
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        w_d       = w_q;
        read_slot = (state_q == StRun) && (k_q != KLast);
        bias_slot = (state_q == StRun) && (k_q == KLast);
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    k_d     = '0;
                    n_d     = '0;
                    w_d     = '0;
                end
            end
            StRun: begin
                if (read_slot) begin
                    k_d = k_q + 1'b1;
                    w_d = w_q + 1'b1;
                end else begin
                    k_d = '0;
                    if (n_q == NLast) begin
                        state_d = StDrain;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                // done is the registered pulse that marks the last result
                if (done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        rd_next = (state_d == StRun) && (k_d != KLast);
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            n_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            w_q     <= w_d;
        end
    end

    // Registered outputs and the control delay pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_en         <= 1'b0;
            data_addr     <= '0;
            weight_addr   <= '0;
            bias_rd_en    <= 1'b0;
            bias_addr     <= '0;
            pe_en         <= 1'b0;
            pe_flush      <= 1'b0;
            pe_bias_en    <= 1'b0;
            out_valid     <= 1'b0;
            out_idx       <= '0;
            flush_p1_q    <= 1'b0;
            en_p1_q       <= 1'b0;
            bias_idx_p2_q <= '0;
        end else begin
            busy  <= (state_d != StIdle);
            rd_en <= rd_next;
            if (rd_next) begin
                data_addr   <= IN_AW'(k_d);
                weight_addr <= w_d;
            end
            // Bias read lands one cycle after the bias slot
            bias_rd_en <= bias_slot;
            if (bias_slot) begin
                bias_addr <= n_q;
            end
            // Products reach the accumulator two cycles after their read
            flush_p1_q    <= rd_en && (data_addr == '0);
            en_p1_q       <= rd_en && (data_addr != '0);
            pe_flush      <= flush_p1_q;
            pe_en         <= en_p1_q;
            pe_bias_en    <= bias_rd_en;
            bias_idx_p2_q <= bias_addr;
            out_valid     <= pe_bias_en;
            done          <= pe_bias_en && (bias_idx_p2_q == NLast);
            if (pe_bias_en) begin
                out_idx <= bias_idx_p2_q;
            end
        end
    end

endmodule

// File: tb/tb_fc_ctrl.sv
// Bench for fc_ctrl: a 4x3 layer with a small memory/PE model, plus a 1x2 layer.
module tb_fc_ctrl;

    localparam int LA = 4;
    localparam int OA = 3;

    typedef struct {
        int cyc;
        int idx;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic       busy_a, done_a, rd_en_a, bias_rd_en_a, pe_en_a, pe_flush_a, pe_bias_en_a;
    logic       out_valid_a;
    logic [1:0] data_addr_a, bias_addr_a, out_idx_a;
    logic [3:0] weight_addr_a;

    logic busy_b, done_b, rd_en_b, bias_rd_en_b, pe_en_b, pe_flush_b, pe_bias_en_b, out_valid_b;
    logic data_addr_b, weight_addr_b, bias_addr_b, out_idx_b;

    fc_ctrl #(.IN_LEN(LA), .OUT_LEN(OA), .IN_AW(2), .W_AW(4), .OUT_AW(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .rd_en(rd_en_a), .data_addr(data_addr_a), .weight_addr(weight_addr_a),
        .bias_rd_en(bias_rd_en_a), .bias_addr(bias_addr_a), .pe_en(pe_en_a),
        .pe_flush(pe_flush_a), .pe_bias_en(pe_bias_en_a), .out_valid(out_valid_a),
        .out_idx(out_idx_a)
    );

    fc_ctrl #(.IN_LEN(1), .OUT_LEN(2), .IN_AW(1), .W_AW(1), .OUT_AW(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .data_addr(data_addr_b), .weight_addr(weight_addr_b),
        .bias_rd_en(bias_rd_en_b), .bias_addr(bias_addr_b), .pe_en(pe_en_b),
        .pe_flush(pe_flush_b), .pe_bias_en(pe_bias_en_b), .out_valid(out_valid_b),
        .out_idx(out_idx_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory + PE model for dut_a: features=2, weights=3, bias=5
    int fdat, wdat, bdat, prod, acc;
    always @(posedge clk) begin
        if (rst) begin
            fdat <= 0; wdat <= 0; bdat <= 0; prod <= 0; acc <= 0;
        end else begin
            fdat <= rd_en_a ? 2 : 0;
            wdat <= rd_en_a ? 3 : 0;
            bdat <= bias_rd_en_a ? 5 : 0;
            prod <= fdat * wdat;
            if (pe_flush_a) acc <= prod;
            else if (pe_en_a) acc <= acc + prod;
            else if (pe_bias_en_a) acc <= acc + bdat;
        end
    end

    // Slot k issued at cycle t for a run started at s, or -1 when no slot
    function automatic int slot_k(int t, int s, int l, int o);
        int r = t - s - 1;
        if (r < 0) return -1;
        if (r / (l + 1) >= o) return -1;
        return r % (l + 1);
    endfunction

    function automatic int slot_n(int t, int s, int l);
        return (t - s - 1) / (l + 1);
    endfunction

    task automatic wait_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        total++;
        if ({busy_a, done_a, rd_en_a, bias_rd_en_a, pe_en_a, pe_flush_a, pe_bias_en_a,
             out_valid_a, data_addr_a, weight_addr_a, bias_addr_a, out_idx_a} !== '0) begin
            bad++;
            $display("FAIL reset_a got busy=%b rd=%b waddr=%0d want all zero", busy_a, rd_en_a,
                     weight_addr_a);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if ({busy_b, done_b, rd_en_b, bias_rd_en_b, pe_en_b, pe_flush_b, pe_bias_en_b,
             out_valid_b, data_addr_b, weight_addr_b, bias_addr_b, out_idx_b} !== '0) begin
            bad++;
            $display("FAIL reset_b got busy=%b rd=%b want all zero", busy_b, rd_en_b);
        end
        total++;
        if ({busy_a, rd_en_a, out_valid_a} !== 3'b000) begin
            bad++;
            $display("FAIL idle_a got busy/rd/ov=%b want 000", {busy_a, rd_en_a, out_valid_a});
        end
        @(posedge clk);
        #1;
    endtask

    // One full 4x3 run started at cycle s, checked every cycle through its done cycle.
    // With extra set, start is also pulsed mid-run and in the done cycle.
    task automatic run_a(input int s, input bit extra);
        int   d = s + OA * (LA + 1) + 3;
        int   k0, k1, k2, k3;
        logic [7:0] exp_v, obs_v;
        exp_t e;
        wait_cycle(s);
        for (int t = s; t <= d; t++) begin
            start_a = (t == s) || (extra && (t == s + 6 || t == d));
            if (t == s) begin
                for (int n = 0; n < OA; n++) qa.push_back('{s + (n + 1) * (LA + 1) + 3, n, 29});
            end
            @(negedge clk);
            k0 = slot_k(t, s, LA, OA);
            k1 = slot_k(t - 1, s, LA, OA);
            k2 = slot_k(t - 2, s, LA, OA);
            k3 = slot_k(t - 3, s, LA, OA);
            exp_v = {k0 >= 0 && k0 < LA, k1 == LA, k2 == 0, k2 >= 1 && k2 < LA, k2 == LA,
                     k3 == LA, k3 == LA && slot_n(t - 3, s, LA) == OA - 1, t >= s + 1 && t <= d};
            obs_v = {rd_en_a, bias_rd_en_a, pe_flush_a, pe_en_a, pe_bias_en_a, out_valid_a,
                     done_a, busy_a};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL ctl_a cyc=%0d got=%b want=%b (rd,brd,fl,en,be,ov,done,busy)",
                         t, obs_v, exp_v);
            end
            total++;
            if ($countones({pe_en_a, pe_flush_a, pe_bias_en_a}) > 1) begin
                bad++;
                $display("FAIL onehot_a cyc=%0d got en/fl/be=%b want at most one", t,
                         {pe_en_a, pe_flush_a, pe_bias_en_a});
            end
            if (k0 >= 0 && k0 < LA) begin
                total++;
                if (int'(data_addr_a) !== k0 ||
                    int'(weight_addr_a) !== slot_n(t, s, LA) * LA + k0) begin
                    bad++;
                    $display("FAIL addr_a cyc=%0d got d=%0d w=%0d want d=%0d w=%0d", t,
                             data_addr_a, weight_addr_a, k0, slot_n(t, s, LA) * LA + k0);
                end
            end
            if (k1 == LA) begin
                total++;
                if (int'(bias_addr_a) !== slot_n(t - 1, s, LA)) begin
                    bad++;
                    $display("FAIL baddr_a cyc=%0d got=%0d want=%0d", t, bias_addr_a,
                             slot_n(t - 1, s, LA));
                end
            end
            if (out_valid_a) begin
                total++;
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL result_a cyc=%0d got unexpected out_valid want none", t);
                end else begin
                    e = qa.pop_front();
                    if (e.cyc !== t || int'(out_idx_a) !== e.idx || acc !== e.val) begin
                        bad++;
                        $display("FAIL result_a got cyc=%0d idx=%0d val=%0d want cyc=%0d idx=%0d val=%0d",
                                 t, out_idx_a, acc, e.cyc, e.idx, e.val);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
        total++;
        if (qa.size() != 0) begin
            bad++;
            $display("FAIL drain_a got %0d results outstanding want 0", qa.size());
        end
    endtask

    task automatic test_basic();
        run_a(10, 1'b0);
    endtask

    // Start pulses while busy and in the done cycle are ignored; the next cycle starts again
    task automatic test_back_to_back();
        run_a(29, 1'b1);
        run_a(29 + OA * (LA + 1) + 4, 1'b0);
    endtask

    task automatic test_reset_midrun(input int s);
        wait_cycle(s);
        for (int t = s; t <= s + 25; t++) begin
            start_a = (t == s);
            rst = (t == s + 10);
            if (t == s + 10) qa.delete();
            @(negedge clk);
            if (t >= s + 11) begin
                total++;
                if ({busy_a, done_a, rd_en_a, bias_rd_en_a, pe_en_a, pe_flush_a, pe_bias_en_a,
                     out_valid_a, data_addr_a, weight_addr_a, bias_addr_a,
                     out_idx_a} !== '0) begin
                    bad++;
                    $display("FAIL rst_mid cyc=%0d got busy=%b rd=%b ov=%b done=%b want all zero",
                             t, busy_a, rd_en_a, out_valid_a, done_a);
                end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start_a = 1'b0;
        run_a(s + 30, 1'b0);
    endtask

    task automatic test_in_len1(input int s);
        logic [6:0] exp_v, obs_v;
        exp_t e;
        wait_cycle(s);
        for (int t = s; t <= s + 9; t++) begin
            start_b = (t == s);
            if (t == s) begin
                qb.push_back('{s + 5, 0, 0});
                qb.push_back('{s + 7, 1, 0});
            end
            @(negedge clk);
            exp_v = {t == s + 1 || t == s + 3, t == s + 3 || t == s + 5, t == s + 3 || t == s + 5,
                     1'b0, t == s + 4 || t == s + 6, t == s + 5 || t == s + 7, t == s + 7};
            obs_v = {rd_en_b, bias_rd_en_b, pe_flush_b, pe_en_b, pe_bias_en_b, out_valid_b,
                     done_b};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL ctl_b cyc=%0d got=%b want=%b (rd,brd,fl,en,be,ov,done)", t,
                         obs_v, exp_v);
            end
            if (out_valid_b) begin
                total++;
                if (qb.size() == 0) begin
                    bad++;
                    $display("FAIL result_b cyc=%0d got unexpected out_valid want none", t);
                end else begin
                    e = qb.pop_front();
                    if (e.cyc !== t || int'(out_idx_b) !== e.idx) begin
                        bad++;
                        $display("FAIL result_b got cyc=%0d idx=%0d want cyc=%0d idx=%0d", t,
                                 out_idx_b, e.cyc, e.idx);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        start_b = 1'b0;
        total++;
        if (qb.size() != 0 || busy_b !== 1'b0) begin
            bad++;
            $display("FAIL end_b got outstanding=%0d busy=%b want 0 and 0", qb.size(), busy_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_midrun(80);
        test_in_len1(150);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no completion by 100000 want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fc_ctrl.md
# fc_ctrl

Sequencer for one `pe_fc` fully connected processing element and its feature, weight and bias memories. On `start` it walks all `OUT_LEN` neurons of the layer. For each neuron it issues `IN_LEN` feature/weight reads and one bias read, then drives the PE's `flush`/`en`/`bias_en` so the pipeline accumulates the products and adds the bias. It flags each finished dot product for the downstream activation/store stage.

## Interface
- `IN_LEN`, default 192: inputs per neuron (dot-product length), ≥1.
- `OUT_LEN`, default 10: neurons in the layer, ≥1.
- `IN_AW`, default 8: feature address width; must hold `IN_LEN-1`.
- `W_AW`, default 11: weight address width; must hold `IN_LEN*OUT_LEN-1`.
- `OUT_AW`, default 4: neuron index and bias address width; must hold `OUT_LEN-1`.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to run the layer; ignored while `busy`.
- `busy` output 1: high from the cycle after `start` is accepted through the `done` cycle.
- `done` output 1: one-cycle pulse, coincident with the last `out_valid`.
- `rd_en` output 1: feature and weight memory read strobe.
- `data_addr` output IN_AW: feature address k.
- `weight_addr` output W_AW: weight address n*IN_LEN+k.
- `bias_rd_en` output 1: bias memory read strobe.
- `bias_addr` output OUT_AW: bias address n.
- `pe_en` output 1: PE accumulate-product.
- `pe_flush` output 1: PE load-first-product.
- `pe_bias_en` output 1: PE add-bias.
- `out_valid` output 1: PE `data_o` holds the final result for neuron `out_idx` this cycle.
- `out_idx` output OUT_AW: neuron index of the current result.

## Operation
- All memories have 1-cycle synchronous read latency. The PE registers the product, so a product reaches the accumulator 2 cycles after its read. Bias is added combinationally in the PE and must be valid in the `pe_bias_en` cycle.
- States:
  - IDLE: `start` moves to RUN.
  - RUN: issue slots.
  - DRAIN: the last neuron's in-flight controls.
  - IDLE again: entered after the `done` cycle.
- Each neuron takes `IN_LEN+1` issue slots: read slots k=0..IN_LEN-1, then one bias slot. Neurons follow back to back with no gaps. Counters are k (0..IN_LEN) and n (0..OUT_LEN-1).
- Weight address is a running counter incremented on every read slot; no multiplier.
- Read slot k: `rd_en`=1, addresses k and weight counter.
- Bias slot at cycle B:
  - `bias_rd_en`=1 with `bias_addr`=n at B+1.
  - `pe_bias_en`=1 at B+2.
  - `out_valid`=1 with `out_idx`=n at B+3.
- PE controls for read slot k fire 2 cycles after the slot: `pe_flush` if k=0, otherwise `pe_en`.
- Next neuron's `pe_flush` coincides with the previous `out_valid`. Consumer samples `data_o` in that cycle; the flush overwrites it at the clock edge.
- `pe_en`, `pe_flush` and `pe_bias_en` are mutually exclusive in every cycle.
- No backpressure: the consumer must accept one result per `IN_LEN+1` cycles.
- `IN_LEN`=1: each neuron is a flush followed by a bias; no `pe_en` pulses.
- DRAIN lasts until the last `out_valid`, with `done` asserted in that cycle.

## Timing
- All outputs are registered. Reset value of every output is 0; state is IDLE, counters are 0, and the delay pipeline is cleared.
- Start accepted at cycle S: first `rd_en` at S+1.
- Neuron n bias slot: B = S+1+n(IN_LEN+1)+IN_LEN.
- Neuron n result: `out_valid` at S+(n+1)(IN_LEN+1)+3.
- Total latency: `done` at S+OUT_LEN(IN_LEN+1)+3; `busy` low and IDLE the next cycle.
- `start` during the `done` cycle is ignored. `start` in the following cycle is accepted.
- `rst` mid-run: at the next edge all outputs are 0 and in-flight controls are dropped; no `out_valid` or `done` appears afterwards.

## Test plan
- IN_LEN=4, OUT_LEN=3, start at cycle 10:
  - `rd_en` high at 11-14, 16-19 and 21-24.
  - `pe_flush` at 13/18/23; `pe_bias_en` at 17/22/27.
  - `out_valid` at 18/23/28 with `out_idx` 0/1/2; `done` at 28; `busy` low at 29.
- Same config with a PE model, features=2, weights=3, bias=5: every result is 29. Weight addresses run 0..11 contiguous.
- IN_LEN=1, OUT_LEN=2, start at 0:
  - `pe_flush` at 3/5 and `pe_bias_en` at 4/6, never `pe_en`.
  - `out_valid` at 5/7; `done` at 7.
- `start` pulsed while `busy`, and again in the `done` cycle: both ignored. `start` the cycle after `done`: new run with first `rd_en` 1 cycle later.
- `rst` asserted at cycle 20 of the first scenario: all outputs 0 from cycle 21. No further `out_valid`. A new `start` reruns from neuron 0 with correct timing.
- Every cycle: assert at most one of `pe_en`/`pe_flush`/`pe_bias_en`. Assert `bias_rd_en` exactly 1 cycle before each `pe_bias_en`.
